// File: rtl/nf10_arb_pkg.sv
// Shared definitions for the NetFPGA-10G round-robin input arbiter:
// arbiter state encoding, tuser field offsets and a sizing helper.
package nf10_arb_pkg;

    // Arbiter states: IDLE searches for a non-empty queue, XFER streams one packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Field offsets inside tuser (first beat of a packet).
    localparam int LEN_LO = 0;   // packet length in bytes
    localparam int SRC_LO = 16;  // source port, one-hot
    localparam int DST_LO = 24;  // destination port

    // Ceiling log2, never below 1 so a select register always has a bit.
    function automatic int log2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_fallthrough_fifo_ar.sv
// Small first-word-fall-through FIFO used to buffer one ingress port.
// The head word is presented on dout whenever empty is low; nearly_full
// asserts with one free slot left so a single in-flight write is safe.
module axis_fallthrough_fifo_ar
    import nf10_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam int CNT_W = DEPTH_BITS + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q;
    logic [DEPTH_BITS-1:0] rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  wr_ok_s;
    logic                  rd_ok_s;

    assign wr_ok_s     = wr_en & (count_q != CNT_W'(DEPTH));
    assign rd_ok_s     = rd_en & (count_q != CNT_W'(0));
    assign dout        = mem_q[rd_ptr_q];
    assign empty       = (count_q == CNT_W'(0));
    assign nearly_full = (count_q >= CNT_W'(DEPTH - 1));

    // Occupancy update; a simultaneous read and write leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/nf10_rr_input_arbiter.sv
// Packet-level round-robin merge of five AXI4-Stream ingress ports into one
// stream. Each port is buffered in a fall-through FIFO; a grant covers exactly
// one packet through tlast, then the pointer moves to the next port.
module nf10_rr_input_arbiter
    import nf10_arb_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH      = 128,
    parameter int NUM_INPUTS        = 5,
    parameter int FIFO_DEPTH_BITS   = 2
) (
    input  logic                           axi_aclk,
    input  logic                           axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_0,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_0,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_0,
    input  logic                           s_axis_tvalid_0,
    output logic                           s_axis_tready_0,
    input  logic                           s_axis_tlast_0,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_1,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_1,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_1,
    input  logic                           s_axis_tvalid_1,
    output logic                           s_axis_tready_1,
    input  logic                           s_axis_tlast_1,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_2,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_2,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_2,
    input  logic                           s_axis_tvalid_2,
    output logic                           s_axis_tready_2,
    input  logic                           s_axis_tlast_2,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_3,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_3,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_3,
    input  logic                           s_axis_tvalid_3,
    output logic                           s_axis_tready_3,
    input  logic                           s_axis_tlast_3,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_4,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_4,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_4,
    input  logic                           s_axis_tvalid_4,
    output logic                           s_axis_tready_4,
    input  logic                           s_axis_tlast_4,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_USER_WIDTH-1:0]        m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    localparam int QW     = log2(NUM_INPUTS);
    localparam int FIFO_W = 1 + C_USER_WIDTH + C_AXIS_DATA_WIDTH / 8 + C_AXIS_DATA_WIDTH;

    logic [FIFO_W-1:0]     din_s  [NUM_INPUTS];
    logic [FIFO_W-1:0]     dout_s [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] s_valid_s;
    logic [NUM_INPUTS-1:0] s_ready_s;
    logic [NUM_INPUTS-1:0] wr_en_s;
    logic [NUM_INPUTS-1:0] rd_en_s;
    logic [NUM_INPUTS-1:0] empty_s;
    logic [NUM_INPUTS-1:0] nfull_s;
    logic [NUM_INPUTS-1:0] sel_s;
    logic [FIFO_W-1:0]     head_s;
    logic                  head_empty_s;
    logic                  head_last_s;
    logic                  m_valid_s;
    logic [QW-1:0]         next_queue_s;

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [QW-1:0]         cur_queue_q;
    logic [QW-1:0]         cur_queue_d;
    logic                  ready_en_q;

    // Port flattening: each FIFO word is {tlast, tuser, tstrb, tdata}.
    assign din_s[0] = {s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0};
    assign din_s[1] = {s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1};
    assign din_s[2] = {s_axis_tlast_2, s_axis_tuser_2, s_axis_tstrb_2, s_axis_tdata_2};
    assign din_s[3] = {s_axis_tlast_3, s_axis_tuser_3, s_axis_tstrb_3, s_axis_tdata_3};
    assign din_s[4] = {s_axis_tlast_4, s_axis_tuser_4, s_axis_tstrb_4, s_axis_tdata_4};

    assign s_valid_s = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                        s_axis_tvalid_1, s_axis_tvalid_0};

    // Ready is held low in reset and the first cycle is spent leaving it.
    assign s_ready_s = {NUM_INPUTS{ready_en_q}} & ~nfull_s;
    assign wr_en_s   = s_valid_s & s_ready_s;

    assign s_axis_tready_0 = s_ready_s[0];
    assign s_axis_tready_1 = s_ready_s[1];
    assign s_axis_tready_2 = s_ready_s[2];
    assign s_axis_tready_3 = s_ready_s[3];
    assign s_axis_tready_4 = s_ready_s[4];

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_fifo
        axis_fallthrough_fifo_ar #(
            .WIDTH      (FIFO_W),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk         (axi_aclk),
            .rst_n       (axi_resetn),
            .wr_en       (wr_en_s[g]),
            .din         (din_s[g]),
            .rd_en       (rd_en_s[g]),
            .dout        (dout_s[g]),
            .empty       (empty_s[g]),
            .nearly_full (nfull_s[g])
        );
    end

    // One-hot select of the current queue and AND-OR mux of its FIFO head.
    always_comb begin
        sel_s        = '0;
        head_s       = '0;
        head_empty_s = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            sel_s[i]     = (cur_queue_q == QW'(i));
            head_s       = head_s | (dout_s[i] & {FIFO_W{sel_s[i]}});
            head_empty_s = head_empty_s & ~(sel_s[i] & ~empty_s[i]);
        end
    end

    assign head_last_s  = head_s[FIFO_W-1];
    assign next_queue_s = (cur_queue_q == QW'(NUM_INPUTS - 1)) ? '0 : cur_queue_q + QW'(1);

    // Arbiter next state: scan in IDLE, hold the grant in XFER until tlast leaves.
    always_comb begin
        state_d     = state_q;
        cur_queue_d = cur_queue_q;
        rd_en_s     = '0;
        m_valid_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!head_empty_s) begin
                    state_d = XFER;
                end else begin
                    cur_queue_d = next_queue_s;
                end
            end
            XFER: begin
                m_valid_s = ~head_empty_s;
                if (m_axis_tready && !head_empty_s) begin
                    rd_en_s = sel_s;
                    if (head_last_s) begin
                        state_d     = IDLE;
                        cur_queue_d = next_queue_s;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    rd_en_s = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                cur_queue_d = '0;
            end
        endcase
    end

    // Arbiter state, grant pointer and post-reset ready enable.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= IDLE;
            cur_queue_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_queue_q <= cur_queue_d;
            ready_en_q  <= 1'b1;
        end
    end

    // Output fields are forced to zero whenever no beat is being offered.
    assign m_axis_tvalid = m_valid_s;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} =
        m_valid_s ? head_s : '0;

endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Randomised bench for nf10_rr_input_arbiter. Per-input scoreboards hold the
// beats accepted at each ingress; every merged beat is matched against the
// queue of the input named in its tdata tag. Packet integrity, no interleave,
// idle bubble, stall stability and a round-robin wait bound are checked.
module tb_nf10_rr_input_arbiter;

    localparam int N  = 5;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_tdata [N];
    logic [SW-1:0] s_tstrb [N];
    logic [UW-1:0] s_tuser [N];
    logic [N-1:0]  s_tvalid;
    logic [N-1:0]  s_tready;
    logic [N-1:0]  s_tlast;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    int     total_cnt;
    int     bad_cnt;
    beat_t  sb [N][$];
    int     rem [N];
    int     pkts_left [N];
    int     len_cfg [N];
    int     hs_cnt [N];
    int     waiting [N];
    logic [15:0] cur_len [N];
    logic [N-1:0] hs;
    int     p_valid;
    int     p_ready;
    int     cyc;
    bit     in_pkt;
    bit     bubble_pending;
    bit     prev_stall;
    int     cur_src;
    beat_t  stall_beat;
    int     seq [$];
    bit     lat_arm;
    int     first_hs;
    int     first_val;

    nf10_rr_input_arbiter dut (
        .axi_aclk        (clk),
        .axi_resetn      (rst_n),
        .s_axis_tdata_0  (s_tdata[0]), .s_axis_tstrb_0 (s_tstrb[0]), .s_axis_tuser_0 (s_tuser[0]),
        .s_axis_tvalid_0 (s_tvalid[0]), .s_axis_tready_0 (s_tready[0]), .s_axis_tlast_0 (s_tlast[0]),
        .s_axis_tdata_1  (s_tdata[1]), .s_axis_tstrb_1 (s_tstrb[1]), .s_axis_tuser_1 (s_tuser[1]),
        .s_axis_tvalid_1 (s_tvalid[1]), .s_axis_tready_1 (s_tready[1]), .s_axis_tlast_1 (s_tlast[1]),
        .s_axis_tdata_2  (s_tdata[2]), .s_axis_tstrb_2 (s_tstrb[2]), .s_axis_tuser_2 (s_tuser[2]),
        .s_axis_tvalid_2 (s_tvalid[2]), .s_axis_tready_2 (s_tready[2]), .s_axis_tlast_2 (s_tlast[2]),
        .s_axis_tdata_3  (s_tdata[3]), .s_axis_tstrb_3 (s_tstrb[3]), .s_axis_tuser_3 (s_tuser[3]),
        .s_axis_tvalid_3 (s_tvalid[3]), .s_axis_tready_3 (s_tready[3]), .s_axis_tlast_3 (s_tlast[3]),
        .s_axis_tdata_4  (s_tdata[4]), .s_axis_tstrb_4 (s_tstrb[4]), .s_axis_tuser_4 (s_tuser[4]),
        .s_axis_tvalid_4 (s_tvalid[4]), .s_axis_tready_4 (s_tready[4]), .s_axis_tlast_4 (s_tlast[4]),
        .m_axis_tdata    (m_tdata),
        .m_axis_tstrb    (m_tstrb),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tlast    (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    function automatic beat_t make_beat(input int k);
        beat_t b;
        for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom;
        b.data[DW-1 -: 8] = 8'(k);
        b.strb = $urandom;
        for (int w = 0; w < 4; w++) b.user[w*32 +: 32] = $urandom;
        b.user[15:0]  = cur_len[k];
        b.user[23:16] = (k < 4) ? (8'h01 << (2 * k)) : 8'h02;
        b.last = (rem[k] == 1);
        return b;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            sb[k].delete();
            rem[k] = 0; pkts_left[k] = 0; len_cfg[k] = 0; waiting[k] = 0; hs_cnt[k] = 0;
        end
        hs = '0; in_pkt = 1'b0; bubble_pending = 1'b0; prev_stall = 1'b0;
    endtask

    // Source-side driver: advance on handshake, hold while stalled, start packets at random.
    task automatic drive();
        beat_t b;
        bit started;
        for (int k = 0; k < N; k++) begin
            if (s_tvalid[k] && hs[k]) begin
                rem[k]--;
                s_tvalid[k] = 1'b0;
            end
            if (!s_tvalid[k]) begin
                started = 1'b0;
                if (rem[k] == 0 && pkts_left[k] > 0 && roll(p_valid)) begin
                    rem[k] = (len_cfg[k] > 0) ? len_cfg[k] : int'($urandom_range(6, 1));
                    cur_len[k] = 16'(rem[k] * 32);
                    pkts_left[k]--;
                    started = 1'b1;
                end
                if (rem[k] > 0 && (started || roll(p_valid))) begin
                    b = make_beat(k);
                    {s_tlast[k], s_tuser[k], s_tstrb[k], s_tdata[k]} = b;
                    s_tvalid[k] = 1'b1;
                end
            end
        end
        m_tready = roll(p_ready);
    endtask

    // Sampling at the falling edge: record accepted input beats, check output beats.
    task automatic monitor();
        beat_t e;
        int lane;
        cyc++;
        for (int k = 0; k < N; k++) begin
            hs[k] = s_tvalid[k] & s_tready[k];
            if (hs[k]) begin
                if (sb[k].size() == 0) waiting[k] = 0;
                sb[k].push_back({s_tlast[k], s_tuser[k], s_tstrb[k], s_tdata[k]});
                hs_cnt[k]++;
                if (lat_arm && first_hs < 0) first_hs = cyc;
            end
        end
        if (lat_arm && m_tvalid && first_val < 0) first_val = cyc;
        if (bubble_pending) begin
            check_eq("idle_bubble", m_tvalid, 1'b0);
            bubble_pending = 1'b0;
        end
        if (prev_stall) begin
            check_eq("stall_valid", m_tvalid, 1'b1);
            check_eq("stall_hold", {m_tlast, m_tuser, m_tstrb, m_tdata}, stall_beat);
        end
        prev_stall = m_tvalid & ~m_tready;
        stall_beat = {m_tlast, m_tuser, m_tstrb, m_tdata};
        if (m_tvalid && m_tready) begin
            lane = int'(m_tdata[DW-1 -: 8]);
            check_eq("src_range", lane < N, 1'b1);
            if (lane < N) begin
                if (in_pkt) begin
                    check_eq("no_interleave", lane, cur_src);
                end else begin
                    seq.push_back(lane);
                    for (int j = 0; j < N; j++) begin
                        if (j != lane && sb[j].size() > 0) begin
                            waiting[j]++;
                            check_eq("fair_wait", waiting[j] <= N - 1, 1'b1);
                        end
                    end
                    waiting[lane] = 0;
                end
                check_eq("sb_avail", sb[lane].size() > 0, 1'b1);
                if (sb[lane].size() > 0) begin
                    e = sb[lane].pop_front();
                    check_eq("beat_data", m_tdata, e.data);
                    check_eq("beat_strb", m_tstrb, e.strb);
                    check_eq("beat_user", m_tuser, e.user);
                    check_eq("beat_last", m_tlast, e.last);
                end
                in_pkt = !m_tlast;
                cur_src = lane;
                bubble_pending = m_tlast;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit is_idle();
        bit r;
        r = !m_tvalid;
        for (int k = 0; k < N; k++) begin
            if (pkts_left[k] != 0 || rem[k] != 0 || s_tvalid[k] || sb[k].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!is_idle() && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, is_idle(), 1'b1);
    endtask

    initial begin
        int n;
        total_cnt = 0; bad_cnt = 0; cyc = 0; lat_arm = 1'b0;
        clear_model();
        rst_n = 1'b0; m_tready = 1'b0; s_tvalid = '0; s_tlast = '0;
        for (int k = 0; k < N; k++) begin
            s_tdata[k] = '0; s_tstrb[k] = '0; s_tuser[k] = '0; cur_len[k] = '0;
        end
        p_valid = 100; p_ready = 100;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", m_tvalid, 1'b0);
        check_eq("rst_tdata", m_tdata, '0);
        check_eq("rst_tuser", m_tuser, '0);
        check_eq("rst_tlast", m_tlast, 1'b0);
        check_eq("rst_tready", s_tready, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("pre_ready", s_tready, 5'h00);
        @(posedge clk);
        #1;
        check_eq("post_ready", s_tready, 5'h1f);

        // 3-beat packet on input 2, latency from first handshake
        pkts_left[2] = 1; len_cfg[2] = 3;
        lat_arm = 1'b1; first_hs = -1; first_val = -1;
        drive();
        run_idle("single3", 40);
        check_eq("latency", first_val - first_hs, 2);
        check_eq("single3_beats", hs_cnt[2], 3);
        lat_arm = 1'b0;

        // Every input loaded with two 1-beat packets at once: strict rotation
        seq.delete();
        for (int k = 0; k < N; k++) begin
            pkts_left[k] = 2; len_cfg[k] = 1;
        end
        run_idle("rr", 150);
        check_eq("rr_count", seq.size(), 10);
        for (int i = 1; i < seq.size(); i++) check_eq("rr_order", seq[i], (seq[0] + i) % N);

        // 6-beat packet into a stalled output: only three writes accepted
        for (int k = 0; k < N; k++) len_cfg[k] = 0;
        pkts_left[0] = 1; len_cfg[0] = 6; hs_cnt[0] = 0;
        p_ready = 0;
        repeat (10) tick();
        check_eq("stall_accepts", hs_cnt[0], 3);
        check_eq("stall_tready0", s_tready[0], 1'b0);
        p_ready = 100;
        run_idle("stall", 60);
        check_eq("stall_total", hs_cnt[0], 6);

        // Random traffic with source gaps and downstream backpressure
        p_valid = 70; p_ready = 70;
        for (int k = 0; k < N; k++) begin
            pkts_left[k] = 10; len_cfg[k] = 0;
        end
        run_idle("random", 6000);

        // Reset pulse during beat 2 of a 4-beat packet
        p_valid = 100; p_ready = 100;
        pkts_left[1] = 1; len_cfg[1] = 4; hs_cnt[1] = 0;
        n = 0;
        while (hs_cnt[1] < 2 && n < 30) begin
            tick();
            n++;
        end
        check_eq("rst_setup", hs_cnt[1], 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_tvalid", m_tvalid, 1'b0);
        check_eq("midrst_tdata", m_tdata, '0);
        check_eq("midrst_tuser", m_tuser, '0);
        check_eq("midrst_tlast", m_tlast, 1'b0);
        check_eq("midrst_tready", s_tready, 5'h00);
        clear_model();
        s_tvalid = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pkts_left[3] = 1; len_cfg[3] = 2;
        run_idle("post_rst", 40);
        check_eq("post_rst_beats", hs_cnt[3], 2);

        // Only input 4 busy: pointer must wrap round to it for every packet
        seq.delete();
        pkts_left[4] = 8; len_cfg[4] = 1; hs_cnt[4] = 0;
        run_idle("lane4", 200);
        check_eq("lane4_in", hs_cnt[4], 8);
        check_eq("lane4_out", seq.size(), 8);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
